// File: rtl/piece_spawn_ctrl.sv
// Falling-piece lifecycle controller: preview queue, spawn, gravity, lock delay
// and hand-off to line clear. All timing is counted in frame ticks.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | not playing; preview queue held flushed
// S_FILL     | waiting for the preview queue to fill
// S_SPAWN    | one cycle: emit spawn pulse for queue head and pop it
// S_FALL     | piece falling; gravity counter runs on frame ticks
// S_LOCK     | piece grounded; lock-delay counter runs on frame ticks
// S_WAIT_CLR | piece locked; waiting for line clear to finish
// S_OVER     | spawn position blocked; game_over held until play stops
module piece_spawn_ctrl #(
    parameter int QDEPTH         = 4,
    parameter int GRAVITY_FRAMES = 30,
    parameter int SOFT_FRAMES    = 3,
    parameter int LOCK_FRAMES    = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] Game_State,
    input  logic [2:0] randnum,
    input  logic       down_held,
    input  logic       blocked,
    input  logic       spawn_blocked,
    input  logic       clear_done,
    output logic [6:0] spawn_onehot,
    output logic       Step_Down,
    output logic       En_New_Static,
    output logic [2:0] next_piece,
    output logic       game_over
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int MAXGS = (GRAVITY_FRAMES > SOFT_FRAMES) ? GRAVITY_FRAMES : SOFT_FRAMES;
    localparam int MAXF  = (MAXGS > LOCK_FRAMES) ? MAXGS : LOCK_FRAMES;
    localparam int CW    = $clog2(MAXF + 1);

    localparam logic [CW-1:0] GRAV_C  = CW'(GRAVITY_FRAMES);
    localparam logic [CW-1:0] SOFT_C  = CW'(SOFT_FRAMES);
    localparam logic [CW:0]   LOCK_W  = (CW + 1)'(LOCK_FRAMES);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW:0]   ONE_W   = (CW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   Q_FULL  = (AW + 1)'(QDEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SPAWN, S_FALL, S_LOCK, S_WAIT_CLR, S_OVER
    } state_t;

    state_t          r_state;
    logic            r_frame_q;
    logic [CW-1:0]   r_gcnt;
    logic [CW-1:0]   r_lcnt;
    logic [2:0]      r_mem [QDEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_cnt;
    logic [6:0]      r_spawn;
    logic            r_step;
    logic            r_lock;
    logic [2:0]      r_next;
    logic            r_over;

    state_t          w_state_n;
    logic [CW-1:0]   w_gcnt_n;
    logic [CW-1:0]   w_lcnt_n;
    logic [6:0]      w_spawn_n;
    logic            w_step_n;
    logic            w_lock_n;
    logic            w_pop;
    logic            w_push;
    logic            w_tick;
    logic            w_play;
    logic            w_pause;
    logic            w_full;
    logic            w_empty;
    logic [2:0]      w_head;
    logic [6:0]      w_onehot;
    logic [CW-1:0]   w_thr;
    logic [CW:0]     w_gnext;
    logic [CW:0]     w_lnext;

    assign w_tick   = frame_clk & ~r_frame_q;
    assign w_play   = (Game_State == 3'b001);
    assign w_pause  = (Game_State == 3'b010);
    assign w_full   = (r_cnt == Q_FULL);
    assign w_empty  = (r_cnt == '0);
    assign w_head   = r_mem[r_rptr];
    assign w_onehot = (w_head == 3'd0) ? 7'd0 : (7'd1 << (w_head - 3'd1));
    assign w_thr    = down_held ? SOFT_C : GRAV_C;
    assign w_gnext  = {1'b0, r_gcnt} + ONE_W;
    assign w_lnext  = {1'b0, r_lcnt} + ONE_W;
    // A full queue may still accept a new ID in the same cycle it is popped.
    assign w_push   = (randnum != 3'd0) && (r_state != S_IDLE) && (r_state != S_OVER)
                      && (!w_full || w_pop);

    // Next-state, counter updates and pulse decisions; pause freezes everything.
    always_comb begin
        w_state_n = r_state;
        w_gcnt_n  = r_gcnt;
        w_lcnt_n  = r_lcnt;
        w_spawn_n = '0;
        w_step_n  = 1'b0;
        w_lock_n  = 1'b0;
        w_pop     = 1'b0;
        if (!w_pause) begin
            if (!w_play && r_state != S_OVER) begin
                w_state_n = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: w_state_n = S_FILL;
                    S_FILL: if (w_full) w_state_n = S_SPAWN;
                    S_SPAWN: begin
                        if (spawn_blocked) begin
                            w_state_n = S_OVER;
                        end else begin
                            w_spawn_n = w_onehot;
                            w_pop     = 1'b1;
                            w_gcnt_n  = '0;
                            w_state_n = S_FALL;
                        end
                    end
                    S_FALL: begin
                        if (w_tick) begin
                            if (w_gnext >= {1'b0, w_thr}) begin
                                w_gcnt_n = '0;
                                if (blocked) begin
                                    w_state_n = S_LOCK;
                                    w_lcnt_n  = '0;
                                end else begin
                                    w_step_n = 1'b1;
                                end
                            end else begin
                                w_gcnt_n = (r_gcnt == CNT_MAX) ? r_gcnt : w_gnext[CW-1:0];
                            end
                        end
                    end
                    S_LOCK: begin
                        // Sliding off the ledge beats a coincident tick.
                        if (!blocked) begin
                            w_state_n = S_FALL;
                            w_gcnt_n  = '0;
                        end else if (w_tick) begin
                            if (w_lnext >= LOCK_W) begin
                                w_lock_n  = 1'b1;
                                w_state_n = S_WAIT_CLR;
                            end else begin
                                w_lcnt_n = (r_lcnt == CNT_MAX) ? r_lcnt : w_lnext[CW-1:0];
                            end
                        end
                    end
                    S_WAIT_CLR: if (clear_done) w_state_n = S_FILL;
                    S_OVER: if (!w_play) w_state_n = S_IDLE;
                    default: w_state_n = S_IDLE;
                endcase
            end
        end
    end

    // State register, counters and frame-edge detector.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_gcnt    <= '0;
            r_lcnt    <= '0;
            r_frame_q <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_gcnt    <= w_gcnt_n;
            r_lcnt    <= w_lcnt_n;
            r_frame_q <= frame_clk;
        end
    end

    // Preview queue storage; only valid IDs are ever written.
    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wptr] <= randnum;
    end

    // Preview queue pointers and occupancy; IDLE keeps the queue flushed.
    always_ff @(posedge Clk) begin
        if (Reset || r_state == S_IDLE) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
            else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_spawn <= '0;
            r_step  <= 1'b0;
            r_lock  <= 1'b0;
            r_next  <= 3'd0;
            r_over  <= 1'b0;
        end else begin
            r_spawn <= w_spawn_n;
            r_step  <= w_step_n;
            r_lock  <= w_lock_n;
            r_next  <= w_empty ? 3'd0 : w_head;
            r_over  <= (w_state_n == S_OVER);
        end
    end

    assign spawn_onehot  = r_spawn;
    assign Step_Down     = r_step;
    assign En_New_Static = r_lock;
    assign next_piece    = r_next;
    assign game_over     = r_over;

endmodule

// File: tb/tb_piece_spawn_ctrl.sv
// Randomized bench for piece_spawn_ctrl with a queue-based reference model
// and a per-cycle output scoreboard.
module tb_piece_spawn_ctrl;

    localparam int QD = 4;
    localparam int GF = 30;
    localparam int SF = 3;
    localparam int LF = 15;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] Game_State;
    logic [2:0] randnum;
    logic       down_held;
    logic       blocked;
    logic       spawn_blocked;
    logic       clear_done;
    logic [6:0] spawn_onehot;
    logic       Step_Down;
    logic       En_New_Static;
    logic [2:0] next_piece;
    logic       game_over;

    piece_spawn_ctrl #(
        .QDEPTH(QD), .GRAVITY_FRAMES(GF), .SOFT_FRAMES(SF), .LOCK_FRAMES(LF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .randnum(randnum), .down_held(down_held), .blocked(blocked),
        .spawn_blocked(spawn_blocked), .clear_done(clear_done),
        .spawn_onehot(spawn_onehot), .Step_Down(Step_Down),
        .En_New_Static(En_New_Static), .next_piece(next_piece), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [6:0] sp;
        logic       st;
        logic       lk;
        logic [2:0] np;
        logic       go;
    } exp_t;

    typedef enum int { M_IDLE, M_FILL, M_SPAWN, M_FALL, M_LOCK, M_WAIT, M_OVER } phase_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;

    phase_t     m_ph;
    logic [2:0] m_q[$];
    int         m_g;
    int         m_l;
    bit         m_fc_prev;
    int         fc_left;

    // Reference model: predicts the outputs seen after the next rising edge.
    task automatic model_step();
        exp_t   e;
        bit     tick;
        bit     pop;
        bit     push;
        int     thr;
        phase_t pre;
        e = '0;
        if (Reset) begin
            m_ph = M_IDLE;
            m_q.delete();
            m_g = 0;
            m_l = 0;
            m_fc_prev = 1'b0;
            exp_q.push_back(e);
            return;
        end
        tick = frame_clk && !m_fc_prev;
        m_fc_prev = frame_clk;
        e.np = (m_q.size() > 0) ? m_q[0] : 3'd0;
        pop = 1'b0;
        pre = m_ph;
        if (Game_State == 3'b010) begin
            // frozen
        end else if (Game_State != 3'b001 && m_ph != M_OVER) begin
            m_ph = M_IDLE;
        end else begin
            case (m_ph)
                M_IDLE: m_ph = M_FILL;
                M_FILL: if (m_q.size() == QD) m_ph = M_SPAWN;
                M_SPAWN: begin
                    if (spawn_blocked) m_ph = M_OVER;
                    else begin
                        e.sp[m_q[0] - 1] = 1'b1;
                        pop = 1'b1;
                        m_g = 0;
                        m_ph = M_FALL;
                    end
                end
                M_FALL: begin
                    if (tick) begin
                        thr = down_held ? SF : GF;
                        if (m_g + 1 >= thr) begin
                            m_g = 0;
                            if (blocked) begin
                                m_ph = M_LOCK;
                                m_l = 0;
                            end else e.st = 1'b1;
                        end else m_g++;
                    end
                end
                M_LOCK: begin
                    if (!blocked) begin
                        m_ph = M_FALL;
                        m_g = 0;
                    end else if (tick) begin
                        if (m_l + 1 == LF) begin
                            e.lk = 1'b1;
                            m_ph = M_WAIT;
                        end else m_l++;
                    end
                end
                M_WAIT: if (clear_done) m_ph = M_FILL;
                M_OVER: if (Game_State != 3'b001) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
        push = (randnum != 3'd0) && (pre != M_IDLE) && (pre != M_OVER)
               && ((m_q.size() < QD) || pop);
        if (pre == M_IDLE) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(randnum);
        end
        e.go = (m_ph == M_OVER);
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: advance the frame clock, predict, wait for next negedge.
    task automatic drive_cycle();
        fc_left--;
        if (fc_left <= 0) begin
            frame_clk = ~frame_clk;
            fc_left = $urandom_range(1, 3);
        end
        model_step();
        @(negedge Clk);
    endtask

    exp_t mon_e;
    exp_t mon_a;

    // Monitor: every rising edge the DUT presents a new output set.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {spawn_onehot, Step_Down, En_New_Static, next_piece, game_over};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got sp=%b st=%b lk=%b np=%0d go=%b expected sp=%b st=%b lk=%b np=%0d go=%b",
                         $time, mon_a.sp, mon_a.st, mon_a.lk, mon_a.np, mon_a.go,
                         mon_e.sp, mon_e.st, mon_e.lk, mon_e.np, mon_e.go);
            end
        end
    end

    initial begin
        int dur;
        int pick;
        bit zero_win;
        bit flicker;
        Reset = 1'b1;
        frame_clk = 1'b0;
        Game_State = 3'b000;
        randnum = 3'd0;
        down_held = 1'b0;
        blocked = 1'b0;
        spawn_blocked = 1'b0;
        clear_done = 1'b0;
        fc_left = 2;
        m_ph = M_IDLE;
        m_g = 0;
        m_l = 0;
        m_fc_prev = 1'b0;

        for (int i = 0; i < 3; i++) drive_cycle();
        Reset = 1'b0;
        Game_State = 3'b001;
        randnum = 3'd3;
        for (int i = 0; i < 40; i++) drive_cycle();

        for (int w = 0; w < 120; w++) begin
            pick = $urandom_range(0, 99);
            if (pick < 3) begin
                Reset = 1'b1;
                drive_cycle();
                drive_cycle();
                Reset = 1'b0;
            end
            pick = $urandom_range(0, 99);
            if (pick < 70)      Game_State = 3'b001;
            else if (pick < 85) Game_State = 3'b010;
            else if (pick < 92) Game_State = 3'b000;
            else                Game_State = 3'($urandom_range(3, 7));
            dur = (Game_State == 3'b001 || Game_State == 3'b010)
                  ? $urandom_range(40, 500) : $urandom_range(3, 30);
            blocked       = ($urandom_range(0, 1) == 1);
            down_held     = ($urandom_range(0, 1) == 1);
            spawn_blocked = ($urandom_range(0, 99) < 15);
            zero_win      = ($urandom_range(0, 9) == 0);
            flicker       = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < dur; c++) begin
                randnum    = zero_win ? 3'd0 : 3'($urandom_range(0, 7));
                clear_done = ($urandom_range(0, 9) == 0);
                if (flicker) blocked = ($urandom_range(0, 3) != 0);
                drive_cycle();
            end
        end
        clear_done = 1'b0;

        @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
